// File: rtl/jk_excitation_seq.sv
// jk_excitation_seq: walks an external JK flip-flop bank to a target value one count per clock.
// Define JK_TOGGLE_PREF_EN to resolve excitation don't-cares toward toggle (J=K=1) instead of set/clear.
module jk_excitation_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q_model,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_cnt
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] target;
  logic             up;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] jk_q;
  logic             fire;
  always_comb begin
    nxt = up ? q_model + 1'b1 : q_model - 1'b1;
`ifdef JK_TOGGLE_PREF_EN
    j = (state == STEP) ? q_model ^ nxt : '0;
    k = (state == STEP) ? q_model ^ nxt : '0;
`else
    j = (state == STEP) ? ~q_model & nxt : '0;
    k = (state == STEP) ? q_model & ~nxt : '0;
`endif
    // Mirror applies the same JK characteristic equation the bank uses.
    jk_q      = (j & ~q_model) | (~k & q_model);
    tgt_ready = reset_n && (state == IDLE);
    busy      = (state == STEP);
    done      = (state == DONE);
    fire      = tgt_valid && tgt_ready;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      q_model  <= '0;
      target   <= '0;
      up       <= 1'b0;
      step_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          target   <= tgt_data;
          step_cnt <= '0;
          up       <= tgt_data > q_model;
          state    <= (tgt_data == q_model) ? DONE : STEP;
        end
        STEP: begin
          q_model  <= jk_q;
          step_cnt <= step_cnt + 1'b1;
          if (jk_q == target) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
